// File: rtl/rf_mp_if.sv
// Datapath-side bundle of the multi-port register file: two write ports,
// packed read ports, the clear request and the status flags.
interface rf_mp_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, clr_req,
    input  rd, busy, wr_drop
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, clr_req,
    output rd, busy, wr_drop
  );
endinterface

// File: rtl/rf_mp.sv
// Multi-port register file: two write ports, NRD combinational read ports,
// optional zero register and write bypass, plus a clear sweep after reset/request.
module rf_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic   clk,
  input logic   rst_n,
  rf_mp_if.slave rf
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       clr_idx_r;
  logic                busy_r;
  logic                wr_drop_r;
  logic [DW-1:0]       mem_r [DEPTH];
  logic                wr_ok_s;
  logic                w0_valid_s;
  logic                w1_valid_s;
  logic                drop_s;
  logic [NRD*DW-1:0]   rd_s;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_V);
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [CW-1:0] to_idx(input logic [AW-1:0] a);
    return a[CW-1:0];
  endfunction

  // Write qualification; the cycle a clear is requested already counts as clearing.
  always_comb begin
    wr_ok_s    = (state_r == ST_IDLE) && !rf.clr_req;
    w0_valid_s = rf.we0 && wr_ok_s && in_range(rf.wa0) && !is_zero(rf.wa0);
    w1_valid_s = rf.we1 && wr_ok_s && in_range(rf.wa1) && !is_zero(rf.wa1);
    drop_s     = (rf.we0 && (!wr_ok_s || !in_range(rf.wa0))) ||
                 (rf.we1 && (!wr_ok_s || !in_range(rf.wa1)));
  end

  // Clear sequencer and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= '0;
      busy_r    <= 1'b1;
      wr_drop_r <= 1'b0;
    end else begin
      wr_drop_r <= drop_s;
      case (state_r)
        ST_IDLE: begin
          if (rf.clr_req) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= '0;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_idx_r == LAST_IDX) begin
            state_r   <= ST_IDLE;
            clr_idx_r <= '0;
            busy_r    <= 1'b0;
          end else begin
            clr_idx_r <= clr_idx_r + CW'(1);
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_idx_r <= '0;
          busy_r    <= 1'b1;
        end
      endcase
    end
  end

  // Storage array; no reset, contents come from the sweep. Port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_idx_r] <= '0;
    end else begin
      if (w0_valid_s) begin
        mem_r[to_idx(rf.wa0)] <= rf.wd0;
      end
      if (w1_valid_s) begin
        mem_r[to_idx(rf.wa1)] <= rf.wd1;
      end
    end
  end

  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (busy_r) begin
      v = '0;
    end else if (is_zero(a)) begin
      v = '0;
    end else if (!in_range(a)) begin
      v = '0;
    end else if ((BYPASS != 0) && w1_valid_s && (rf.wa1 == a)) begin
      v = rf.wd1;
    end else if ((BYPASS != 0) && w0_valid_s && (rf.wa0 == a)) begin
      v = rf.wd0;
    end else begin
      v = mem_r[to_idx(a)];
    end
    return v;
  endfunction

  // Zero-latency read ports.
  always_comb begin
    rd_s = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_s[k*DW +: DW] = read_port(rf.ra[k*AW +: AW]);
    end
  end

  assign rf.rd      = rd_s;
  assign rf.busy    = busy_r;
  assign rf.wr_drop = wr_drop_r;

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: a 32-entry bypassing instance and a 24-entry
// non-bypassing instance, checked through an expected-value queue.
module tb_rf_mp;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   k;
  int   f0;
  int   f1;

  always #5 clk = ~clk;

  rf_mp_if #(.DW(32), .AW(5), .NRD(2)) ifc0 ();
  rf_mp_if #(.DW(32), .AW(5), .NRD(2)) ifc1 ();

  rf_mp #(.DW(32), .AW(5), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rf(ifc0)
  );

  rf_mp #(.DW(32), .AW(5), .DEPTH(24), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .rf(ifc1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic setra(input logic [4:0] a0, input logic [4:0] a1);
    ifc0.ra = {a1, a0};
  endtask

  task automatic idle_all();
    ifc0.we0 = 1'b0; ifc0.we1 = 1'b0; ifc0.clr_req = 1'b0;
    ifc1.we0 = 1'b0; ifc1.we1 = 1'b0; ifc1.clr_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      tick();
      setra(5'(i), 5'(31 - i));
      push({tag, "_p0"}, 32'h0);
      push({tag, "_p1"}, 32'h0);
      #1;
      chk(ifc0.rd[31:0]);
      chk(ifc0.rd[63:32]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_all();
    ifc0.wa0 = 5'd0; ifc0.wd0 = 32'h0; ifc0.wa1 = 5'd0; ifc0.wd1 = 32'h0; ifc0.ra = 10'h0;
    ifc1.wa0 = 5'd0; ifc1.wd0 = 32'h0; ifc1.wa1 = 5'd0; ifc1.wd1 = 32'h0; ifc1.ra = 10'h0;

    // reset state
    #12;
    push("rst_busy0", 32'h1);  chk(32'(ifc0.busy));
    push("rst_busy1", 32'h1);  chk(32'(ifc1.busy));
    push("rst_drop0", 32'h0);  chk(32'(ifc0.wr_drop));
    push("rst_rd0", 32'h0);    chk(ifc0.rd[31:0]);
    tick();
    tick();
    rst_n = 1'b1;

    // sweep length after reset release
    k = 0; f0 = 0; f1 = 0;
    while ((f0 == 0 || f1 == 0) && k < 200) begin
      tick();
      k++;
      if (!ifc0.busy && f0 == 0) f0 = k;
      if (!ifc1.busy && f1 == 0) f1 = k;
    end
    push("sweep_len0", 32'd32); chk(32'(f0));
    push("sweep_len1", 32'd24); chk(32'(f1));
    check_all_zero("post_rst");

    // basic write with same-cycle bypass
    tick();
    ifc0.we0 = 1'b1; ifc0.wa0 = 5'd5; ifc0.wd0 = 32'hDEADBEEF;
    setra(5'd5, 5'd0);
    push("byp_same", 32'hDEADBEEF);
    #1 chk(ifc0.rd[31:0]);
    tick();
    ifc0.we0 = 1'b0;
    push("wr_hold", 32'hDEADBEEF);
    push("drop_basic", 32'h0);
    #1 chk(ifc0.rd[31:0]);
    chk(32'(ifc0.wr_drop));

    // both ports writing different addresses, each bypassed to its own read port
    tick();
    ifc0.we0 = 1'b1; ifc0.wa0 = 5'd8; ifc0.wd0 = 32'h88;
    ifc0.we1 = 1'b1; ifc0.wa1 = 5'd9; ifc0.wd1 = 32'h99;
    setra(5'd8, 5'd9);
    push("byp_w0", 32'h88);
    push("byp_w1", 32'h99);
    #1 chk(ifc0.rd[31:0]);
    chk(ifc0.rd[63:32]);

    // zero register
    tick();
    ifc0.we1 = 1'b0;
    ifc0.we0 = 1'b1; ifc0.wa0 = 5'd0; ifc0.wd0 = 32'h12345678;
    setra(5'd0, 5'd0);
    push("zr_same", 32'h0);
    #1 chk(ifc0.rd[31:0]);
    tick();
    ifc0.we0 = 1'b0;
    push("zr_drop", 32'h0);
    push("zr_next", 32'h0);
    #1 chk(32'(ifc0.wr_drop));
    chk(ifc0.rd[31:0]);

    // collision: port 1 wins
    tick();
    ifc0.we0 = 1'b1; ifc0.wa0 = 5'd7; ifc0.wd0 = 32'h1;
    ifc0.we1 = 1'b1; ifc0.wa1 = 5'd7; ifc0.wd1 = 32'h2;
    setra(5'd7, 5'd7);
    push("coll_byp", 32'h2);
    #1 chk(ifc0.rd[63:32]);
    tick();
    ifc0.we0 = 1'b0; ifc0.we1 = 1'b0;
    push("coll_rd", 32'h2);
    push("coll_drop", 32'h0);
    #1 chk(ifc0.rd[31:0]);
    chk(32'(ifc0.wr_drop));

    // no bypass: old value this cycle, new value next cycle
    tick();
    ifc1.we0 = 1'b1; ifc1.wa0 = 5'd5; ifc1.wd0 = 32'hDEADBEEF;
    ifc1.ra = {5'd0, 5'd5};
    push("nobyp_old", 32'h0);
    #1 chk(ifc1.rd[31:0]);
    tick();
    ifc1.we0 = 1'b0;
    push("nobyp_new", 32'hDEADBEEF);
    #1 chk(ifc1.rd[31:0]);

    // out-of-range write on the 24-entry instance
    tick();
    ifc1.we0 = 1'b1; ifc1.wa0 = 5'd30; ifc1.wd0 = 32'h55;
    ifc1.ra = {5'd30, 5'd30};
    tick();
    ifc1.we0 = 1'b0;
    push("oor_drop", 32'h1);
    push("oor_rd", 32'h0);
    #1 chk(32'(ifc1.wr_drop));
    chk(ifc1.rd[31:0]);
    tick();
    push("oor_pulse", 32'h0);
    chk(32'(ifc1.wr_drop));

    // fill 1..31 with index values
    for (int i = 1; i < 32; i += 2) begin
      ifc0.we0 = 1'b1; ifc0.wa0 = 5'(i);     ifc0.wd0 = 32'(i);
      ifc0.we1 = (i + 1 < 32); ifc0.wa1 = 5'(i + 1); ifc0.wd1 = 32'(i + 1);
      tick();
    end
    ifc0.we0 = 1'b0; ifc0.we1 = 1'b0;
    setra(5'd17, 5'd31);
    push("fill17", 32'd17);
    push("fill31", 32'd31);
    #1 chk(ifc0.rd[31:0]);
    chk(ifc0.rd[63:32]);

    // clear request with a write in the same cycle
    tick();
    ifc0.clr_req = 1'b1;
    ifc0.we0 = 1'b1; ifc0.wa0 = 5'd3; ifc0.wd0 = 32'hAA;
    tick();
    ifc0.clr_req = 1'b0; ifc0.we0 = 1'b0;
    setra(5'd3, 5'd17);
    push("clr_busy", 32'h1);
    push("clr_drop", 32'h1);
    push("clr_rd_busy", 32'h0);
    #1 chk(32'(ifc0.busy));
    chk(32'(ifc0.wr_drop));
    chk(ifc0.rd[31:0]);

    // sweep with a write and a second clear request inside it
    k = 0; f0 = 0;
    while (f0 == 0 && k < 200) begin
      ifc0.we0 = (k == 5);
      ifc0.wa0 = 5'd9; ifc0.wd0 = 32'h77;
      ifc0.clr_req = (k == 10);
      tick();
      k++;
      if (k == 6) begin
        push("sweep_drop", 32'h1);
        chk(32'(ifc0.wr_drop));
      end
      if (!ifc0.busy && f0 == 0) f0 = k;
    end
    idle_all();
    push("clr_len", 32'd32);
    chk(32'(f0));
    check_all_zero("post_clr");

    // async reset during a sweep
    tick();
    ifc0.we0 = 1'b1; ifc0.wa0 = 5'd20; ifc0.wd0 = 32'h20;
    ifc0.we1 = 1'b1; ifc0.wa1 = 5'd2;  ifc0.wd1 = 32'h22;
    tick();
    idle_all();
    ifc0.clr_req = 1'b1;
    tick();
    ifc0.clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    push("arst_busy", 32'h1);
    push("arst_drop", 32'h0);
    chk(32'(ifc0.busy));
    chk(32'(ifc0.wr_drop));
    tick();
    tick();
    rst_n = 1'b1;
    k = 0; f0 = 0;
    while (f0 == 0 && k < 200) begin
      tick();
      k++;
      if (!ifc0.busy && f0 == 0) f0 = k;
    end
    push("arst_len", 32'd32);
    chk(32'(f0));
    tick();
    setra(5'd20, 5'd2);
    push("arst_rd20", 32'h0);
    push("arst_rd2", 32'h0);
    #1 chk(ifc0.rd[31:0]);
    chk(ifc0.rd[63:32]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
